// File: rtl/pim_row_load_sequencer.sv
// Row-load sequencer for the PIM crossbar: takes a row count on start_load, then
// writes one upstream word per consecutive row, each write lasting WR_LAT cycles.
module pim_row_load_sequencer #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 16,
  parameter int ADDR_W = $clog2(ROWS),
  parameter int WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic [ADDR_W:0]   num_rows,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] row_addr,
  output logic [DATA_W-1:0] row_data,
  output logic              row_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WC_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [ADDR_W:0] ROWS_C = (ADDR_W+1)'(ROWS);
  localparam logic [ADDR_W:0] ONE_C  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic [WC_W-1:0]   wr_cnt_reg, wr_cnt_next;
  logic [ADDR_W-1:0] row_addr_reg, row_addr_next;
  logic [DATA_W-1:0] row_data_reg, row_data_next;
  logic              row_we_reg, row_we_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      wr_cnt_reg   <= '0;
      row_addr_reg <= '0;
      row_data_reg <= '0;
      row_we_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wr_cnt_reg   <= wr_cnt_next;
      row_addr_reg <= row_addr_next;
      row_data_reg <= row_data_next;
      row_we_reg   <= row_we_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    wr_cnt_next   = wr_cnt_reg;
    row_addr_next = row_addr_reg;
    row_data_next = row_data_reg;
    row_we_next   = 1'b0;
    err_next      = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (start_load) begin
          if (num_rows != '0 && num_rows <= ROWS_C) begin
            cnt_next      = num_rows;
            row_addr_next = '0;
            state_next    = S_ACCEPT;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          row_data_next = in_data;
          wr_cnt_next   = WC_W'(WR_LAT - 1);
          row_we_next   = 1'b1;
          state_next    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_cnt_reg == '0) begin
          if ({1'b0, row_addr_reg} == cnt_reg - ONE_C) begin
            state_next = S_DONE;
          end else begin
            row_addr_next = row_addr_reg + 1'b1;
            state_next    = S_ACCEPT;
          end
        end else begin
          wr_cnt_next = wr_cnt_reg - 1'b1;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // busy/done are registered copies of the decode of the upcoming state
    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_DONE);
  end

  assign in_ready = (state_reg == S_ACCEPT);
  assign row_addr = row_addr_reg;
  assign row_data = row_data_reg;
  assign row_we   = row_we_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule
